alien_march_controller: RTL and testbench

Owns the alien formation: position, per-alien alive mask, march timing, and edge bounce/drop. It is the producer of `alien_reached_paddle`, which the game-over logic consumes. It freezes while `game_over` is high and re-spawns the formation when `game_over` falls. It also drives the per-pixel `active_alien` flag to the display mux, and takes kill requests from the bullet collision logic.

---
 rtl/alien_march_controller_pkg.sv | 26 ++
 rtl/alien_march_controller_extents.sv | 47 ++++
 rtl/alien_march_controller.sv | 172 +++++++++++++++++
 tb/tb_alien_march_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alien_march_controller_pkg.sv
// Shared constants for the alien march block: screen geometry, formation defaults
// and the march state encoding.
package alien_march_controller_pkg;

  localparam int HRES     = 640;
  localparam int VRES     = 480;
  localparam int PADDLE_H = 16;

  localparam int DEF_ALIEN_COLS  = 8;
  localparam int DEF_ALIEN_ROWS  = 4;
  localparam int DEF_COL_PITCH   = 32;
  localparam int DEF_ROW_PITCH   = 16;
  localparam int DEF_ALIEN_W     = 24;
  localparam int DEF_ALIEN_H     = 12;
  localparam int DEF_START_X     = 32;
  localparam int DEF_START_Y     = 32;
  localparam int DEF_HSTEP       = 4;
  localparam int DEF_VDROP       = 8;
  localparam int DEF_STEP_PERIOD = 4;

  typedef logic [1:0] march_state_t;
  localparam march_state_t RUN    = 2'd0;
  localparam march_state_t LANDED = 2'd1;
  localparam march_state_t FROZEN = 2'd2;

endpackage

// File: rtl/alien_march_controller_extents.sv
// Combinational extents of the live formation: leftmost/rightmost live column,
// bottom live row and an any-alive flag.
module alien_live_extents
  import alien_march_controller_pkg::*;
#(
  parameter int ALIEN_COLS = DEF_ALIEN_COLS,
  parameter int ALIEN_ROWS = DEF_ALIEN_ROWS
) (
  input  logic [ALIEN_COLS*ALIEN_ROWS-1:0] alive,
  output logic [3:0]                       left_col,
  output logic [3:0]                       right_col,
  output logic [2:0]                       bottom_row,
  output logic                             any_alive
);

  logic [ALIEN_COLS-1:0] col_any;
  logic [ALIEN_ROWS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ALIEN_ROWS; r++) begin
      for (int c = 0; c < ALIEN_COLS; c++) begin
        if (alive[r*ALIEN_COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
  end

  // Later assignments win, so scan order picks the extreme index.
  always_comb begin
    left_col   = '0;
    right_col  = '0;
    bottom_row = '0;
    for (int c = ALIEN_COLS - 1; c >= 0; c--)
      if (col_any[c]) left_col = 4'(c);
    for (int c = 0; c < ALIEN_COLS; c++)
      if (col_any[c]) right_col = 4'(c);
    for (int r = 0; r < ALIEN_ROWS; r++)
      if (row_any[r]) bottom_row = 3'(r);
  end

  assign any_alive = |col_any;

endmodule

// File: rtl/alien_march_controller.sv
// Alien formation owner: march timing, edge bounce/drop, kills, landing and the
// per-pixel sprite flag. Define ALIEN_SPEEDUP_EN to shorten the step period per wave.
module alien_march_controller
  import alien_march_controller_pkg::*;
#(
  parameter int ALIEN_COLS  = DEF_ALIEN_COLS,
  parameter int ALIEN_ROWS  = DEF_ALIEN_ROWS,
  parameter int COL_PITCH   = DEF_COL_PITCH,
  parameter int ROW_PITCH   = DEF_ROW_PITCH,
  parameter int ALIEN_W     = DEF_ALIEN_W,
  parameter int ALIEN_H     = DEF_ALIEN_H,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int HSTEP       = DEF_HSTEP,
  parameter int VDROP       = DEF_VDROP,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               game_over,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               kill_valid,
  input  logic [3:0]         kill_col,
  input  logic [2:0]         kill_row,
  output logic               active_alien,
  output logic               alien_reached_paddle,
  output logic signed [11:0] form_x,
  output logic signed [11:0] form_y,
  output logic [7:0]         aliens_left,
  output logic               wave_clear
);

  localparam int CELLS = ALIEN_COLS * ALIEN_ROWS;
  localparam int CSH   = $clog2(COL_PITCH);
  localparam int RSH   = $clog2(ROW_PITCH);
  localparam logic signed [12:0] HSTEP_S   = 13'(HSTEP);
  localparam logic signed [12:0] VDROP_S   = 13'(VDROP);
  localparam logic signed [12:0] ALIEN_W_S = 13'(ALIEN_W);
  localparam logic signed [12:0] ALIEN_H_S = 13'(ALIEN_H);
  localparam logic signed [12:0] START_X_S = 13'(START_X);
  localparam logic signed [12:0] START_Y_S = 13'(START_Y);
  localparam logic signed [12:0] RIGHT_LIM = 13'(HRES);
  localparam logic signed [12:0] LAND_LIM  = 13'(VRES - PADDLE_H);

  march_state_t       state;
  logic signed [12:0] pos_x, pos_y;
  logic               dir_left;
  logic [CELLS-1:0]   alive;
  logic [15:0]        frame_cnt, cur_period;
  logic               go_q;

  logic [3:0] left_col, right_col;
  logic [2:0] bottom_row;
  logic       any_alive;

  alien_live_extents #(
    .ALIEN_COLS(ALIEN_COLS),
    .ALIEN_ROWS(ALIEN_ROWS)
  ) u_extents (
    .alive     (alive),
    .left_col  (left_col),
    .right_col (right_col),
    .bottom_row(bottom_row),
    .any_alive (any_alive)
  );

  logic game_over_fall, respawn;
  assign game_over_fall = go_q && !game_over;
  assign respawn = rst || game_over_fall || (wave_clear && !game_over);

`ifdef ALIEN_SPEEDUP_EN
  logic [15:0] period_q;
  always_ff @(posedge pixel_clk) begin
    if (rst || game_over_fall)
      period_q <= 16'(STEP_PERIOD);
    else if (wave_clear && !game_over && period_q > 16'd1)
      period_q <= period_q - 16'd1;
  end
  assign cur_period = period_q;
`else
  assign cur_period = 16'(STEP_PERIOD);
`endif

  // Step candidate; the extents come from the mask before any same-cycle kill.
  logic signed [12:0] nx, next_x, next_y, col_l_off, col_r_off, row_b_off;
  logic bounce, lands, frame_wrap, step;
  assign nx        = dir_left ? pos_x - HSTEP_S : pos_x + HSTEP_S;
  assign col_l_off = $signed({9'd0, left_col} << CSH);
  assign col_r_off = $signed({9'd0, right_col} << CSH);
  assign row_b_off = $signed({10'd0, bottom_row} << RSH);
  assign bounce    = dir_left ? (nx + col_l_off < 13'sd0)
                              : (nx + col_r_off + ALIEN_W_S > RIGHT_LIM);
  assign next_x    = bounce ? pos_x : nx;
  assign next_y    = bounce ? pos_y + VDROP_S : pos_y;
  assign lands     = (next_y + row_b_off + ALIEN_H_S >= LAND_LIM);
  assign frame_wrap = fsync && (frame_cnt == cur_period - 16'd1);
  assign step       = frame_wrap && any_alive;

  logic [CELLS-1:0] kill_mask;
  logic             kill_hit;
  always_comb begin
    kill_mask = '0;
    for (int r = 0; r < ALIEN_ROWS; r++)
      for (int c = 0; c < ALIEN_COLS; c++)
        if (kill_col == 4'(c) && kill_row == 3'(r)) kill_mask[r*ALIEN_COLS+c] = 1'b1;
  end
  assign kill_hit = kill_valid && |(kill_mask & alive);

  logic signed [12:0] dx, dy;
  logic [12:0] cell_c, cell_r, lo_x, lo_y;
  logic        pix_hit;
  assign dx     = {hpos[11], hpos} - pos_x;
  assign dy     = {vpos[11], vpos} - pos_y;
  assign cell_c = $unsigned(dx) >> CSH;
  assign cell_r = $unsigned(dy) >> RSH;
  assign lo_x   = $unsigned(dx) & 13'(COL_PITCH - 1);
  assign lo_y   = $unsigned(dy) & 13'(ROW_PITCH - 1);

  always_comb begin
    pix_hit = 1'b0;
    if (!dx[12] && !dy[12] && lo_x < 13'(ALIEN_W) && lo_y < 13'(ALIEN_H))
      for (int r = 0; r < ALIEN_ROWS; r++)
        for (int c = 0; c < ALIEN_COLS; c++)
          if (cell_c == 13'(c) && cell_r == 13'(r) && alive[r*ALIEN_COLS+c]) pix_hit = 1'b1;
  end

  // Respawn beats freeze, freeze beats marching; LANDED simply holds.
  always_ff @(posedge pixel_clk) begin
    wave_clear <= 1'b0;
    if (respawn) begin
      state       <= RUN;
      pos_x       <= START_X_S;
      pos_y       <= START_Y_S;
      dir_left    <= 1'b0;
      alive       <= '1;
      frame_cnt   <= '0;
      aliens_left <= 8'(CELLS);
    end else if (game_over) begin
      state <= FROZEN;
    end else if (state == RUN) begin
      if (fsync) frame_cnt <= frame_wrap ? 16'd0 : frame_cnt + 16'd1;
      if (step) begin
        pos_x <= next_x;
        pos_y <= next_y;
        if (bounce) dir_left <= !dir_left;
        if (lands) state <= LANDED;
      end
      if (kill_hit) begin
        alive       <= alive & ~kill_mask;
        aliens_left <= aliens_left - 8'd1;
        wave_clear  <= (aliens_left == 8'd1);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      go_q         <= 1'b0;
      active_alien <= 1'b0;
    end else begin
      go_q         <= game_over;
      active_alien <= pix_hit;
    end
  end

  assign alien_reached_paddle = (state == LANDED);
  assign form_x = pos_x[11:0];
  assign form_y = pos_y[11:0];

endmodule

// File: tb/tb_alien_march_controller.sv
// Self-checking bench for alien_march_controller: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the formation.
module tb_alien_march_controller;

  localparam int COLS = 8, ROWS = 4, CPITCH = 32, RPITCH = 16, AW = 24, AH = 12;
  localparam int SX = 32, SY = 32, HSTEP = 4, VDROP = 8, SP = 4;
  localparam int HRES = 640, VRES = 480, PADDLE_H = 16;
  localparam int S_RUN = 0, S_LANDED = 1, S_FROZEN = 2;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1, fsync = 1'b0, game_over = 1'b0, kill_valid = 1'b0;
  logic [3:0] kill_col = '0;
  logic [2:0] kill_row = '0;
  logic signed [11:0] hpos = '0, vpos = '0;
  logic active_alien, alien_reached_paddle, wave_clear;
  logic signed [11:0] form_x, form_y;
  logic [7:0] aliens_left;

  int checks = 0, errors = 0;
  int m_x, m_y, m_dir, m_state, m_frame, m_period, m_left;
  bit m_go_q, m_wave, m_active;
  bit m_alive[ROWS][COLS];
  bit rand_pix = 1'b1;

  always #5 pixel_clk = ~pixel_clk;

  alien_march_controller dut (
    .pixel_clk           (pixel_clk),
    .rst                 (rst),
    .fsync               (fsync),
    .game_over           (game_over),
    .hpos                (hpos),
    .vpos                (vpos),
    .kill_valid          (kill_valid),
    .kill_col            (kill_col),
    .kill_row            (kill_row),
    .active_alien        (active_alien),
    .alien_reached_paddle(alien_reached_paddle),
    .form_x              (form_x),
    .form_y              (form_y),
    .aliens_left         (aliens_left),
    .wave_clear          (wave_clear)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic spawn_model();
    m_x = SX; m_y = SY; m_dir = 1; m_state = S_RUN; m_frame = 0; m_left = COLS * ROWS;
    foreach (m_alive[r, c]) m_alive[r][c] = 1'b1;
  endtask

  // One clock edge of the formation, using the inputs the DUT just sampled.
  task automatic model_edge();
    int dx, dy, lc, rc, br, nx;
    bit hit, prev_wave, fall, go;
    go = game_over;
    dx = int'(hpos) - m_x;
    dy = int'(vpos) - m_y;
    hit = 1'b0;
    if (dx >= 0 && dy >= 0 && dx / CPITCH < COLS && dy / RPITCH < ROWS)
      if (dx % CPITCH < AW && dy % RPITCH < AH) hit = m_alive[dy / RPITCH][dx / CPITCH];
    if (rst) begin
      spawn_model(); m_period = SP; m_go_q = 1'b0; m_wave = 1'b0; m_active = 1'b0;
    end else begin
      m_active = hit; prev_wave = m_wave; m_wave = 1'b0;
      fall = m_go_q && !go; m_go_q = go;
      if (fall) begin
        spawn_model(); m_period = SP;
      end else if (go) begin
        m_state = S_FROZEN;
      end else if (prev_wave) begin
        spawn_model();
`ifdef ALIEN_SPEEDUP_EN
        if (m_period > 1) m_period--;
`endif
      end else if (m_state == S_RUN) begin
        if (fsync) begin
          if (m_frame == m_period - 1) begin
            m_frame = 0;
            if (m_left > 0) begin
              lc = COLS; rc = -1; br = -1;
              foreach (m_alive[r, c]) if (m_alive[r][c]) begin
                if (c < lc) lc = c;
                if (c > rc) rc = c;
                if (r > br) br = r;
              end
              nx = m_x + m_dir * HSTEP;
              if ((m_dir > 0 && nx + rc * CPITCH + AW > HRES) || (m_dir < 0 && nx + lc * CPITCH < 0)) begin
                m_y += VDROP; m_dir = -m_dir;
              end else m_x = nx;
              if (m_y + br * RPITCH + AH >= VRES - PADDLE_H) m_state = S_LANDED;
            end
          end else m_frame++;
        end
        if (kill_valid && kill_col < COLS && kill_row < ROWS && m_alive[kill_row][kill_col]) begin
          m_alive[kill_row][kill_col] = 1'b0;
          m_left--;
          if (m_left == 0) m_wave = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    if (rand_pix) begin
      hpos = 12'(m_x - 8 + int'($urandom_range(0, 280)));
      vpos = 12'(m_y - 8 + int'($urandom_range(0, 80)));
    end
    @(posedge pixel_clk);
    model_edge();
    #1;
    checkOutput("form_x", int'(form_x), m_x);
    checkOutput("form_y", int'(form_y), m_y);
    checkOutput("aliens_left", int'(aliens_left), m_left);
    checkOutput("wave_clear", int'(wave_clear), int'(m_wave));
    checkOutput("reached", int'(alien_reached_paddle), int'(m_state == S_LANDED));
    checkOutput("active_alien", int'(active_alien), int'(m_active));
    fsync = 1'b0;
    kill_valid = 1'b0;
  endtask

  task automatic kill(input int c, input int r);
    kill_valid = 1'b1; kill_col = 4'(c); kill_row = 3'(r);
  endtask

  initial begin
    int n, max_x, pulses, r, tmp, exp_period;
    int order[32];
    spawn_model(); m_period = SP; m_go_q = 1'b0; m_wave = 1'b0; m_active = 1'b0;

    rst = 1'b1;
    repeat (3) applyStimulus();
    rst = 1'b0;
    checkOutput("rst_form_x", int'(form_x), 32);
    checkOutput("rst_form_y", int'(form_y), 32);
    checkOutput("rst_aliens", int'(aliens_left), 32);
    checkOutput("rst_reached", int'(alien_reached_paddle), 0);
    checkOutput("rst_wave", int'(wave_clear), 0);
    checkOutput("rst_active", int'(active_alien), 0);

    kill(0, 0); applyStimulus();
    kill(0, 0); applyStimulus();
    checkOutput("kill_twice_count", int'(aliens_left), 31);
    rand_pix = 1'b0;
    hpos = 12'sd32; vpos = 12'sd32; applyStimulus();
    checkOutput("dead_cell_dark", int'(active_alien), 0);
    hpos = 12'sd64; vpos = 12'sd32; applyStimulus();
    checkOutput("live_cell_lit", int'(active_alien), 1);
    rand_pix = 1'b1;

    for (int i = 0; i < 360; i++) begin fsync = 1'b1; applyStimulus(); end
    checkOutput("edge_x", int'(form_x), 392);
    checkOutput("edge_y", int'(form_y), 32);
    for (int i = 0; i < 4; i++) begin fsync = 1'b1; applyStimulus(); end
    checkOutput("bounce_x", int'(form_x), 392);
    checkOutput("bounce_y", int'(form_y), 40);
    for (int i = 0; i < 4; i++) begin fsync = 1'b1; applyStimulus(); end
    checkOutput("moving_left_x", int'(form_x), 388);

    for (int i = 0; i < ROWS; i++) begin kill(7, i); applyStimulus(); end
    checkOutput("col7_count", int'(aliens_left), 27);
    n = 0; max_x = 0;
    while (form_y != 12'sd56 && n < 3000) begin
      fsync = 1'b1; applyStimulus(); n++;
      if (form_y == 12'sd48 && int'(form_x) > max_x) max_x = int'(form_x);
    end
    checkOutput("sweep_to_y56", int'(form_y), 56);
    checkOutput("right_limit_x", max_x, 424);

    n = 0;
    while (!alien_reached_paddle && n < 40000) begin
      fsync = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 6);
        kill(int'($urandom_range(0, 15)), (r < 3) ? r : r + 1);
      end
      applyStimulus(); n++;
    end
    checkOutput("landed", int'(alien_reached_paddle), 1);
    checkOutput("land_y", int'(form_y), 408);
    for (int i = 0; i < 12; i++) begin fsync = 1'b1; kill(1, 3); applyStimulus(); end
    checkOutput("landed_hold_y", int'(form_y), 408);

    game_over = 1'b1;
    applyStimulus(); applyStimulus();
    checkOutput("go_flag_clear", int'(alien_reached_paddle), 0);
    kill(2, 1); fsync = 1'b1; applyStimulus();
    game_over = 1'b0; applyStimulus();
    checkOutput("restart_x", int'(form_x), 32);
    checkOutput("restart_y", int'(form_y), 32);
    checkOutput("restart_aliens", int'(aliens_left), 32);

    for (int i = 0; i < 32; i++) order[i] = i;
    for (int i = 31; i > 0; i--) begin
      r = $urandom_range(0, i); tmp = order[i]; order[i] = order[r]; order[r] = tmp;
    end
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      kill(order[i] % COLS, order[i] / COLS); applyStimulus();
      if (wave_clear) pulses++;
    end
    repeat (2) begin applyStimulus(); if (wave_clear) pulses++; end
    checkOutput("wave_pulses", pulses, 1);
    checkOutput("wave_respawn_aliens", int'(aliens_left), 32);
    checkOutput("wave_respawn_x", int'(form_x), 32);
`ifdef ALIEN_SPEEDUP_EN
    exp_period = 3;
`else
    exp_period = 4;
`endif
    n = 0;
    while (form_x == 12'sd32 && n < 10) begin fsync = 1'b1; applyStimulus(); n++; end
    checkOutput("fsyncs_per_step", n, exp_period);

    for (int i = 0; i < 1500; i++) begin
      fsync = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 9) == 0) kill(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) game_over = !game_over;
      rst = ($urandom_range(0, 699) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
